// File: rtl/result_stream_pkg.sv
// Shared constants and types for the result byte-stream transmitter.
// Frame layout: NUM_ELEM result words, then sum, then one XOR checksum byte.
package result_stream_pkg;

    localparam int NUM_ELEM       = 8;
    localparam int DATA_W         = 24;
    localparam int BYTES_PER_WORD = DATA_W / 8;
    localparam int TOTAL_BYTES    = (NUM_ELEM + 1) * BYTES_PER_WORD + 1;

    // word_idx must reach NUM_ELEM, which selects the sum word
    localparam int WORD_IDX_W = $clog2(NUM_ELEM + 1);
    localparam int BYTE_IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        CSUM
    } state_t;

    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/result_stream_tx.sv
// Captures a result vector and its sum on start, then streams them MSB byte
// first over valid/ready, closing the frame with an XOR checksum byte.
module result_stream_tx
    import result_stream_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  word_t       c_vector [NUM_ELEM],
    input  word_t       sum,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done,
    output logic        overrun
);

    state_t state, next_state;

    word_t                  cap_vec [NUM_ELEM];
    word_t                  cap_sum;
    logic [WORD_IDX_W-1:0]  word_idx;
    logic [BYTE_IDX_W-1:0]  byte_idx;
    logic [7:0]             csum;
    word_t                  cur_word;
    logic [7:0]             cur_byte;
    logic                   fire;
    logic                   last_byte;
    logic                   last_word;

    assign tx_valid  = (state != IDLE);
    assign busy      = (state != IDLE);
    assign fire      = tx_valid && tx_ready;
    assign last_byte = (byte_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));
    assign last_word = (word_idx == WORD_IDX_W'(NUM_ELEM));

    // Word index NUM_ELEM falls through to the captured sum
    always_comb begin
        cur_word = cap_sum;
        for (int i = 0; i < NUM_ELEM; i++) begin
            if (word_idx == WORD_IDX_W'(i)) begin
                cur_word = cap_vec[i];
            end
        end
        cur_byte = '0;
        for (int b = 0; b < BYTES_PER_WORD; b++) begin
            if (byte_idx == BYTE_IDX_W'(b)) begin
                cur_byte = cur_word[(BYTES_PER_WORD - 1 - b) * 8 +: 8];
            end
        end
    end

    always_comb begin
        tx_data = '0;
        case (state)
            SEND:    tx_data = cur_byte;
            CSUM:    tx_data = csum;
            default: tx_data = '0;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = SEND;
            SEND: if (fire && last_byte && last_word) next_state = CSUM;
            CSUM: if (fire) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ELEM; i++) begin
                cap_vec[i] <= '0;
            end
            cap_sum  <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            csum     <= '0;
            done     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            done <= (state == CSUM) && fire;
            if (start && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        cap_vec  <= c_vector;
                        cap_sum  <= sum;
                        csum     <= '0;
                        word_idx <= '0;
                        byte_idx <= '0;
                    end
                end
                SEND: begin
                    if (fire) begin
                        csum <= csum ^ cur_byte;
                        if (last_byte) begin
                            byte_idx <= '0;
                            if (!last_word) begin
                                word_idx <= word_idx + 1'b1;
                            end
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                end
                CSUM: begin
                    if (fire) begin
                        word_idx <= '0;
                        byte_idx <= '0;
                    end
                end
                default: begin
                    word_idx <= '0;
                    byte_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_stream_tx.sv
// Bench for result_stream_tx: a frame-level byte-queue model checked every
// cycle, plus literal byte expectations for each directed scenario.
module tb_result_stream_tx;
    import result_stream_pkg::*;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       start    = 1'b0;
    logic       tx_ready = 1'b0;
    word_t      c_vec [NUM_ELEM];
    word_t      sum_in;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       busy;
    logic       done;
    logic       overrun;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] rec [$];
    logic [7:0] exp_q [$];
    bit         m_busy = 0;
    bit         m_done = 0;
    bit         m_over = 0;
    bit         next_busy;
    bit         next_done;
    bit         prev_stall = 0;
    logic [7:0] prev_data = '0;

    always #5 clk = ~clk;

    result_stream_tx dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .c_vector (c_vec),
        .sum      (sum_in),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done),
        .overrun  (overrun)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Expected frame from the current inputs: words MSB byte first, then XOR of all
    function automatic void buildFrame();
        logic [7:0] x;
        word_t      w;
        x = '0;
        exp_q.delete();
        for (int j = 0; j <= NUM_ELEM; j++) begin
            w = (j == NUM_ELEM) ? sum_in : c_vec[j];
            for (int b = BYTES_PER_WORD - 1; b >= 0; b--) begin
                exp_q.push_back(w[b*8 +: 8]);
                x = x ^ w[b*8 +: 8];
            end
        end
        exp_q.push_back(x);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            checkOutput("rst_tx_valid", tx_valid, 0);
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_done", done, 0);
            checkOutput("rst_overrun", overrun, 0);
            checkOutput("rst_tx_data", tx_data, 0);
            m_busy = 0;
            m_done = 0;
            m_over = 0;
            prev_stall = 0;
            exp_q.delete();
        end else begin
            checkOutput("busy", busy, m_busy);
            checkOutput("tx_valid", tx_valid, m_busy);
            checkOutput("done", done, m_done);
            checkOutput("overrun", overrun, m_over);
            if (prev_stall) checkOutput("stall_hold", tx_data, prev_data);
            next_busy = m_busy;
            next_done = 0;
            if (m_busy && tx_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("extra_byte", 1, 0);
                end else begin
                    checkOutput("tx_data", tx_data, exp_q[0]);
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) begin
                        next_busy = 0;
                        next_done = 1;
                    end
                end
                rec.push_back(tx_data);
            end
            if (start) begin
                if (m_busy) m_over = 1;
                else begin
                    buildFrame();
                    next_busy = 1;
                end
            end
            prev_stall = m_busy && !tx_ready;
            prev_data  = tx_data;
            m_busy = next_busy;
            m_done = next_done;
        end
    end

    task automatic setBasic();
        for (int j = 0; j < NUM_ELEM; j++) c_vec[j] = word_t'(j + 1);
        sum_in = 24'h000024;
    endtask

    task automatic setOnes();
        for (int j = 0; j < NUM_ELEM; j++) c_vec[j] = 24'hFFFFFF;
        sum_in = 24'hFFFFF8;
    endtask

    task automatic applyStimulus();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        bit found;
        found = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done) begin
                found = 1;
                break;
            end
        end
        checkOutput("done_seen", found, 1);
    endtask

    task automatic waitBytes(input int n, input int budget);
        bit found;
        found = 0;
        for (int i = 0; i < budget; i++) begin
            if (rec.size() >= n) begin
                found = 1;
                break;
            end
            @(posedge clk); #1;
        end
        checkOutput("bytes_reached", found, 1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "[TB] simulation did not complete");
    end

    initial begin
        bit found;
        int stall_cnt;
        bit stalled;
        for (int j = 0; j < NUM_ELEM; j++) c_vec[j] = '0;
        sum_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tx_ready = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] basic frame");
        setBasic();
        rec.delete();
        applyStimulus();
        waitDone(100);
        checkOutput("basic_len", rec.size(), TOTAL_BYTES);
        checkOutput("basic_b2", rec[2], 8'h01);
        checkOutput("basic_b23", rec[23], 8'h08);
        checkOutput("basic_b26", rec[26], 8'h24);
        checkOutput("basic_csum", rec[27], 8'h2C);
        @(posedge clk); #1;
        checkOutput("basic_busy_after", busy, 0);

        $display("[TB] all-ones frame");
        setOnes();
        rec.delete();
        applyStimulus();
        waitDone(100);
        checkOutput("ones_len", rec.size(), TOTAL_BYTES);
        checkOutput("ones_b0", rec[0], 8'hFF);
        checkOutput("ones_b26", rec[26], 8'hF8);
        checkOutput("ones_csum", rec[27], 8'hF8);

        $display("[TB] backpressure");
        setBasic();
        rec.delete();
        applyStimulus();
        found = 0;
        stalled = 0;
        stall_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (done) begin
                found = 1;
                break;
            end
            if (!stalled && rec.size() >= 10) begin
                stalled = 1;
                stall_cnt = 5;
            end
            if (stall_cnt > 0) begin
                tx_ready = 1'b0;
                stall_cnt--;
            end else begin
                tx_ready = ($urandom_range(0, 3) != 0);
            end
        end
        tx_ready = 1'b1;
        checkOutput("bp_done_seen", found, 1);
        checkOutput("bp_len", rec.size(), TOTAL_BYTES);
        checkOutput("bp_b11", rec[11], 8'h04);
        checkOutput("bp_csum", rec[27], 8'h2C);

        $display("[TB] overrun and frozen capture");
        setBasic();
        rec.delete();
        applyStimulus();
        waitBytes(5, 100);
        for (int j = 0; j < NUM_ELEM; j++) c_vec[j] = 24'hABCDEF;
        sum_in = 24'h123456;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        waitDone(100);
        checkOutput("ovr_len", rec.size(), TOTAL_BYTES);
        checkOutput("ovr_b5", rec[5], 8'h02);
        checkOutput("ovr_csum", rec[27], 8'h2C);
        checkOutput("ovr_flag", overrun, 1);
        repeat (3) @(posedge clk);
        #1 checkOutput("ovr_sticky", overrun, 1);

        $display("[TB] back-to-back");
        setBasic();
        rec.delete();
        applyStimulus();
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (done) begin
                found = 1;
                checkOutput("b2b_busy_done_cycle", busy, 0);
                setOnes();
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                checkOutput("b2b_busy_next", busy, 1);
                break;
            end
        end
        checkOutput("b2b_first_done", found, 1);
        waitDone(100);
        checkOutput("b2b_len", rec.size(), 2 * TOTAL_BYTES);
        checkOutput("b2b_csum1", rec[27], 8'h2C);
        checkOutput("b2b_b28", rec[28], 8'hFF);
        checkOutput("b2b_csum2", rec[55], 8'hF8);

        $display("[TB] reset mid-frame");
        setBasic();
        rec.delete();
        applyStimulus();
        waitBytes(10, 100);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", tx_valid, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_overrun", overrun, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1 checkOutput("post_rst_idle", tx_valid, 0);
        rec.delete();
        applyStimulus();
        waitDone(100);
        checkOutput("post_rst_len", rec.size(), TOTAL_BYTES);
        checkOutput("post_rst_b8", rec[8], 8'h03);
        checkOutput("post_rst_csum", rec[27], 8'h2C);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
